// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared types and constants for the instruction fetch stage
//
// Contents:
//   NOP_INST        instruction presented to decode when nothing is valid
//   DROP_CNT_W      width of the stale-response drop counter
//   fb_state_e      fetch buffer entry state (EMPTY / PENDING / VALID)
//   if_stage_out_t  {inst, pc} pair handed to decode
package if_stage_pkg;

  localparam int unsigned IF_DATA_W  = 32;
  localparam int unsigned IF_ADDR_W  = 32;
  localparam int unsigned DROP_CNT_W = 16;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    VALID   = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic [IF_DATA_W-1:0] inst;
    logic [IF_ADDR_W-1:0] pc;
  } if_stage_out_t;

endpackage

// File: rtl/if_stage_fetch_buf.sv
// rtl/if_stage_fetch_buf.sv - in-order ring buffer of outstanding and returned fetches
//
// Ports:
//   clk, arst_n     clock, asynchronous active-low reset
//   i_flush         empty every entry and reset all pointers (highest priority)
//   i_alloc         claim the entry at the alloc pointer as PENDING with i_alloc_pc
//   o_alloc_empty   entry at the alloc pointer is EMPTY (a request may be issued)
//   i_fill          response arrived; completes the oldest PENDING entry with i_fill_data
//   i_pop           retire the head entry
//   o_head_*        head entry state/contents
//   o_pending_cnt   number of PENDING entries
//   o_valid_cnt     number of VALID entries (only with IF_PERF_CNT_EN)
module fetch_buf
  import if_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        i_flush,
  input  logic                        i_alloc,
  input  logic [ADDR_WIDTH-1:0]       i_alloc_pc,
  output logic                        o_alloc_empty,
  input  logic                        i_fill,
  input  logic [DATA_WIDTH-1:0]       i_fill_data,
  input  logic                        i_pop,
  output logic                        o_head_valid,
  output logic [DATA_WIDTH-1:0]       o_head_inst,
  output logic [ADDR_WIDTH-1:0]       o_head_pc,
  output logic [$clog2(BUF_DEPTH):0]  o_pending_cnt
`ifdef IF_PERF_CNT_EN
  ,
  output logic [$clog2(BUF_DEPTH):0]  o_valid_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fb_state_e             r_state [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc    [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] r_inst  [BUF_DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_alloc;
  logic [PTR_W-1:0]      r_fill;
  logic                  w_fill_hit;
  logic [CNT_W-1:0]      w_pend_cnt;

  // Entries are allocated and filled in order, so the PENDING entries form a
  // contiguous run starting at r_fill. If r_fill is not PENDING, nothing is
  // outstanding and a response is ignored.
  assign w_fill_hit    = i_fill && (r_state[r_fill] == PENDING);
  assign o_alloc_empty = (r_state[r_alloc] == EMPTY);
  assign o_head_valid  = (r_state[r_head] == VALID);
  assign o_head_inst   = r_inst[r_head];
  assign o_head_pc     = r_pc[r_head];
  assign o_pending_cnt = w_pend_cnt;

  always_comb begin
    w_pend_cnt = '0;
    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
      if (r_state[i] == PENDING) w_pend_cnt = w_pend_cnt + CNT_W'(1);
    end
  end

`ifdef IF_PERF_CNT_EN
  always_comb begin
    o_valid_cnt = '0;
    for (int i = 0; i < int'(BUF_DEPTH); i++) begin
      if (r_state[i] == VALID) o_valid_cnt = o_valid_cnt + CNT_W'(1);
    end
  end
`endif

  // Alloc, fill and pop always target different entries (EMPTY, PENDING and
  // VALID respectively), so they can all update in the same cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        r_state[i] <= EMPTY;
        r_pc[i]    <= '0;
        r_inst[i]  <= '0;
      end
      r_head  <= '0;
      r_alloc <= '0;
      r_fill  <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        r_state[i] <= EMPTY;
      end
      r_head  <= '0;
      r_alloc <= '0;
      r_fill  <= '0;
    end else begin
      if (i_alloc) begin
        r_state[r_alloc] <= PENDING;
        r_pc[r_alloc]    <= i_alloc_pc;
        r_alloc          <= r_alloc + PTR_W'(1);
      end
      if (w_fill_hit) begin
        r_state[r_fill] <= VALID;
        r_inst[r_fill]  <= i_fill_data;
        r_fill          <= r_fill + PTR_W'(1);
      end
      if (i_pop) begin
        r_state[r_head] <= EMPTY;
        r_head          <= r_head + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, fetch requests, response buffering, redirects
//
// Optional feature macro: IF_PERF_CNT_EN (adds perf_fetched / perf_flushed)
//
// Ports:
//   clk, arst_n                        clock, asynchronous active-low reset
//   imem_req_valid/ready/addr          fetch request channel to instruction memory
//   imem_rsp_valid/data                in-order responses, always accepted
//   redirect_valid/pc                  control-flow redirect from execute
//   id_ready                           decode accepts an instruction
//   if_valid/if_inst/if_pc             instruction and its pc towards decode
//   perf_fetched/perf_flushed          delivered / discarded fetch counters (IF_PERF_CNT_EN)
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  id_ready,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_inst,
  output logic [ADDR_WIDTH-1:0] if_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushed
`endif
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_alloc_empty;
  logic                  w_req_fire;
  logic                  w_head_valid;
  logic [DATA_WIDTH-1:0] w_head_inst;
  logic [ADDR_WIDTH-1:0] w_head_pc;
  logic [CNT_W-1:0]      w_pend_cnt;
  logic                  w_pop;
  logic                  w_rsp_drop;
  logic                  w_fill;
  logic                  w_redir_discard;
  logic [DROP_CNT_W-1:0] w_drop_next;
  logic                  w_unused_pc_lsb;
`ifdef IF_PERF_CNT_EN
  logic [CNT_W-1:0]      w_valid_cnt;
`endif

  // Redirect targets are forced word aligned; the low bits are dropped.
  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  // Reset gates the request so nothing is offered to memory while the
  // buffer is held empty by reset.
  assign imem_req_valid = arst_n && !redirect_valid && w_alloc_empty;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign if_valid = w_head_valid && !redirect_valid;
  assign if_inst  = if_valid ? w_head_inst : DATA_WIDTH'(NOP_INST);
  assign if_pc    = if_valid ? w_head_pc : '0;
  assign w_pop    = if_valid && id_ready;

  // While stale fetches from before a redirect are still outstanding, the
  // next responses belong to them and are swallowed by the drop counter.
  assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_fill     = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;

  // On redirect every PENDING entry becomes a stale response still to come.
  // A response arriving in the redirect cycle itself is thrown away and
  // retires one of those outstanding fetches (either an old stale one or the
  // oldest PENDING entry); with nothing outstanding it is simply ignored.
  assign w_redir_discard = imem_rsp_valid && ((r_drop_cnt != '0) || (w_pend_cnt != '0));
  assign w_drop_next     = r_drop_cnt + DROP_CNT_W'(w_pend_cnt) - DROP_CNT_W'(w_redir_discard);

  fetch_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_fetch_buf (
    .clk           (clk),
    .arst_n        (arst_n),
    .i_flush       (redirect_valid),
    .i_alloc       (w_req_fire),
    .i_alloc_pc    (r_pc),
    .o_alloc_empty (w_alloc_empty),
    .i_fill        (w_fill),
    .i_fill_data   (imem_rsp_data),
    .i_pop         (w_pop),
    .o_head_valid  (w_head_valid),
    .o_head_inst   (w_head_inst),
    .o_head_pc     (w_head_pc),
    .o_pending_cnt (w_pend_cnt)
`ifdef IF_PERF_CNT_EN
    ,
    .o_valid_cnt   (w_valid_cnt)
`endif
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_pc       <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      r_drop_cnt <= w_drop_next;
    end else begin
      if (w_req_fire) r_pc <= r_pc + ADDR_WIDTH'(4);
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - DROP_CNT_W'(1);
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_flushed;

  // Each lost fetch is counted once: VALID entries when flushed, PENDING
  // entries when their response is discarded.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (w_pop) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (redirect_valid) begin
        r_perf_flushed <= r_perf_flushed + 32'(w_valid_cnt) + 32'(w_redir_discard);
      end else if (w_rsp_drop) begin
        r_perf_flushed <= r_perf_flushed + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed table-driven bench for if_stage
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  always #5 clk = ~clk;

  if_stage #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0100),
    .BUF_DEPTH  (4)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc)
  );

  typedef struct {
    logic        rdy;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        redir;
    logic [31:0] rpc;
    logic        idr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic rsp_v, input logic [31:0] rsp_d,
                     input logic redir, input logic [31:0] rpc, input logic idr,
                     input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.rdy = rdy; v.rsp_v = rsp_v; v.rsp_d = rsp_d; v.redir = redir; v.rpc = rpc; v.idr = idr;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc; v.e_inst = e_inst;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rdy, input logic rsp_v, input logic [31:0] rsp_d,
                       input logic redir, input logic [31:0] rpc, input logic idr);
    imem_req_ready = rdy;
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_d;
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_ready       = idr;
  endtask

  task automatic check_out(input string tag, input logic e_rv, input logic [31:0] e_addr,
                           input logic e_iv, input logic [31:0] e_pc, input logic [31:0] e_inst);
    chk({tag, " req_valid"}, {31'd0, imem_req_valid}, {31'd0, e_rv});
    chk({tag, " req_addr"},  imem_req_addr, e_addr);
    chk({tag, " if_valid"},  {31'd0, if_valid}, {31'd0, e_iv});
    chk({tag, " if_pc"},     if_pc, e_pc);
    chk({tag, " if_inst"},   if_inst, e_inst);
  endtask

  initial begin
    // rdy rsp_v rsp_d        redir rpc       idr | rv addr        iv pc          inst
    add(1, 0, 32'h0,          0, 32'h0,    1,   1, 32'h100,  0, 32'h0,    NOP);
    add(1, 1, 32'hC000_0100,  0, 32'h0,    1,   1, 32'h104,  0, 32'h0,    NOP);
    add(1, 1, 32'hC000_0104,  0, 32'h0,    1,   1, 32'h108,  1, 32'h100,  32'hC000_0100);
    add(1, 1, 32'hC000_0108,  0, 32'h0,    1,   1, 32'h10C,  1, 32'h104,  32'hC000_0104);
    add(1, 1, 32'hC000_010C,  0, 32'h0,    1,   1, 32'h110,  1, 32'h108,  32'hC000_0108);
    add(1, 1, 32'hC000_0110,  0, 32'h0,    1,   1, 32'h114,  1, 32'h10C,  32'hC000_010C);
    // decode stalls: buffer fills, requests stop, head holds
    add(1, 1, 32'hC000_0114,  0, 32'h0,    0,   1, 32'h118,  1, 32'h110,  32'hC000_0110);
    add(1, 1, 32'hC000_0118,  0, 32'h0,    0,   1, 32'h11C,  1, 32'h110,  32'hC000_0110);
    add(1, 1, 32'hC000_011C,  0, 32'h0,    0,   0, 32'h120,  1, 32'h110,  32'hC000_0110);
    add(1, 0, 32'h0,          0, 32'h0,    0,   0, 32'h120,  1, 32'h110,  32'hC000_0110);
    // release: freed slot only reusable next cycle; memory stalls request once
    add(1, 0, 32'h0,          0, 32'h0,    1,   0, 32'h120,  1, 32'h110,  32'hC000_0110);
    add(0, 0, 32'h0,          0, 32'h0,    1,   1, 32'h120,  1, 32'h114,  32'hC000_0114);
    add(1, 0, 32'h0,          0, 32'h0,    1,   1, 32'h120,  1, 32'h118,  32'hC000_0118);
    add(1, 0, 32'h0,          0, 32'h0,    1,   1, 32'h124,  1, 32'h11C,  32'hC000_011C);
    // redirect with two PENDING entries; two stale responses follow
    add(1, 0, 32'h0,          1, 32'h2002, 1,   0, 32'h128,  0, 32'h0,    NOP);
    add(1, 1, 32'hC000_0120,  0, 32'h0,    1,   1, 32'h2000, 0, 32'h0,    NOP);
    add(1, 1, 32'hC000_0124,  0, 32'h0,    1,   1, 32'h2004, 0, 32'h0,    NOP);
    add(1, 1, 32'hC000_2000,  0, 32'h0,    1,   1, 32'h2008, 0, 32'h0,    NOP);
    add(1, 1, 32'hC000_2004,  0, 32'h0,    1,   1, 32'h200C, 1, 32'h2000, 32'hC000_2000);
    // redirect coinciding with a response and a would-be pop
    add(1, 1, 32'hC000_2008,  1, 32'h3000, 1,   0, 32'h2010, 0, 32'h0,    NOP);
    add(1, 1, 32'hC000_200C,  0, 32'h0,    1,   1, 32'h3000, 0, 32'h0,    NOP);
    add(1, 1, 32'hC000_3000,  0, 32'h0,    1,   1, 32'h3004, 0, 32'h0,    NOP);
    add(1, 1, 32'hC000_3004,  0, 32'h0,    1,   1, 32'h3008, 1, 32'h3000, 32'hC000_3000);
    add(0, 1, 32'hC000_3008,  0, 32'h0,    1,   1, 32'h300C, 1, 32'h3004, 32'hC000_3004);
    add(0, 0, 32'h0,          0, 32'h0,    1,   1, 32'h300C, 1, 32'h3008, 32'hC000_3008);

    arst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    repeat (3) @(negedge clk);
    #1 check_out("reset", 0, 32'h100, 0, 32'h0, NOP);

    @(negedge clk);
    arst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rdy, vecs[i].rsp_v, vecs[i].rsp_d, vecs[i].redir, vecs[i].rpc, vecs[i].idr);
      #1 check_out($sformatf("v%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_iv,
                   vecs[i].e_pc, vecs[i].e_inst);
      @(negedge clk);
    end

    // pc wraps from 0xFFFF_FFFC to 0
    drive(1, 0, 32'h0, 1, 32'hFFFF_FFFC, 0);
    #1 chk("wrap redirect req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(negedge clk);
    drive(1, 0, 32'h0, 0, 32'h0, 0);
    #1 chk("wrap first addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap first req_valid", {31'd0, imem_req_valid}, 32'd1);
    @(negedge clk);
    drive(1, 1, 32'hAAAA_0001, 0, 32'h0, 0);
    #1 chk("wrap next addr", imem_req_addr, 32'h0000_0000);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    #1 check_out("wrap head", 1, 32'h4, 1, 32'hFFFF_FFFC, 32'hAAAA_0001);

    // async reset mid-cycle with one VALID and one PENDING entry
    #2 arst_n = 1'b0;
    #1 check_out("async reset", 0, 32'h100, 0, 32'h0, NOP);
    @(negedge clk);
    drive(1, 1, 32'hBAD0_0000, 0, 32'h0, 1);
    @(negedge clk);
    arst_n = 1'b1;
    drive(1, 1, 32'hBAD0_0004, 0, 32'h0, 1);
    #1 check_out("restart c0", 1, 32'h100, 0, 32'h0, NOP);
    @(negedge clk);
    drive(1, 1, 32'hC000_0100, 0, 32'h0, 1);
    #1 check_out("late rsp ignored", 1, 32'h104, 0, 32'h0, NOP);
    @(negedge clk);
    drive(1, 0, 32'h0, 0, 32'h0, 1);
    #1 chk("restart if_valid", {31'd0, if_valid}, 32'd1);
    chk("restart if_pc", if_pc, 32'h100);
    chk("restart if_inst", if_inst, 32'hC000_0100);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage, directly upstream of the decode stage.
- Holds the PC and issues in-order fetch requests to instruction memory over a valid/ready request channel.
- Collects responses into a small in-order fetch buffer and presents {pc, inst} to decode with a valid/ready handshake.
- Services redirects from branch/jump resolution by flushing in-flight and buffered fetches.

Parameters:
DATA_WIDTH, 32, instruction/data width in bits
ADDR_WIDTH, 32, PC and fetch address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUF_DEPTH, 4, fetch buffer entries; power of two, at least 2

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_WIDTH  fetch address (word aligned)
imem_rsp_valid  in  1  response valid; responses are in order, always accepted
imem_rsp_data  in  DATA_WIDTH  fetched instruction
redirect_valid  in  1  control-flow redirect from EX
redirect_pc  in  ADDR_WIDTH  redirect target
id_ready  in  1  decode can accept an instruction
if_valid  out  1  if_inst/if_pc valid
if_inst  out  DATA_WIDTH  instruction to decode
if_pc  out  ADDR_WIDTH  PC of if_inst

Behaviour:
Reset (arst_n low, async):
- pc = RESET_PC; all buffer entries EMPTY; head/alloc pointers = 0; drop_cnt = 0.
- Outputs: imem_req_valid = 0, if_valid = 0, if_inst = NOP (32'h0000_0013), if_pc = 0.
- A response arriving while no entry is PENDING is ignored.

Buffer entry states: EMPTY, PENDING, VALID. Each entry holds the pc captured at allocation plus the inst.

Request:
- imem_req_valid = !redirect_valid && (entry at alloc pointer is EMPTY); imem_req_addr = pc.
- On handshake: alloc entry -> PENDING with pc; alloc pointer +1 (wraps mod BUF_DEPTH); pc <= pc + 4. PC wraps naturally at 2^ADDR_WIDTH.

Response:
- If drop_cnt > 0, discard the response and decrement drop_cnt.
- Otherwise the oldest PENDING entry -> VALID with inst = imem_rsp_data.

Output:
- if_valid = (head entry VALID) && !redirect_valid; if_inst/if_pc come from the head entry.
- When if_valid = 0: if_inst = NOP, if_pc = 0.
- On if_valid && id_ready: head -> EMPTY, head pointer +1.
- Latency: response in cycle M gives if_valid in cycle M+1, with no bypass.
- With a 1-cycle memory and BUF_DEPTH = 4, throughput is 1 instruction/cycle.
- A slot freed by a pop may be reallocated in the next cycle, not the same cycle.

Redirect (priority over everything in that cycle):
- pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; all entries -> EMPTY; pointers reset to 0.
- drop_cnt <= drop_cnt + (number of PENDING entries) - (1 if a response arrives this cycle and is discarded, else 0); a response arriving in the redirect cycle is discarded.
- No request is issued and no pop occurs in the redirect cycle.
- The first request to the target is issued the next cycle.

Backpressure:
- id_ready = 0 holds the head entry stable.
- The buffer fills, then imem_req_valid drops when the alloc entry is not EMPTY.
- imem_req_valid, once asserted, stays asserted with a stable addr until ready or until a redirect.

Optional Feature:
IF_PERF_CNT_EN:
- Defined: adds outputs perf_fetched (32 bits, counts if_valid && id_ready) and perf_flushed (32 bits, counts entries and responses discarded by redirect). Both counters reset to 0 and wrap.
- Undefined: ports and logic are absent.

Decomposition:
- Package if_stage_pkg holds:
  - typedef if_stage_out_t {inst, pc}; decode's input struct is built from it.
  - enum fb_state_e {EMPTY, PENDING, VALID}.
  - constant NOP_INST = 32'h0000_0013.
- Sub-module fetch_buf: ring buffer holding state, pointers, alloc/fill/pop/flush ports.
- if_stage keeps the pc register, request control and drop_cnt.

Test Plan:
- Reset with RESET_PC = 32'h100, imem_req_ready = 1, 1-cycle memory, id_ready = 1 -> addr sequence 0x100, 0x104, 0x108; if_valid from cycle 2; one instruction/cycle thereafter.
- id_ready = 0 for 10 cycles -> exactly 4 requests issued, then imem_req_valid = 0; if_pc holds 0x100; release -> 0x100..0x10C delivered in order with no gaps or duplicates.
- Redirect to 0x2002 with 2 PENDING entries -> if_valid = 0 that cycle; next request addr = 0x2000; the 2 stale responses are dropped; the first delivered pc is 0x2000.
- Redirect in the same cycle as a response and a pop -> neither the pop nor the response is visible at decode; drop_cnt accounts correctly; no stale instruction is emitted.
- pc = 32'hFFFF_FFFC fetch -> next addr = 0x0000_0000.
- Async reset asserted mid-stream with entries VALID and PENDING -> if_valid = 0 immediately; a late response after reset is ignored; fetch restarts at RESET_PC.
